// File: rtl/pss_peak_detector.sv
// Purpose : detects PSS correlation peaks in an unsigned magnitude stream.
//           A sample triggers when it reaches an absolute floor and exceeds
//           2^DETECTION_SHIFT times the moving average of the preceding
//           WINDOW_LEN samples. The maximum over the next PEAK_SPAN samples
//           is then reported, after which HOLDOFF_LEN samples are ignored.
// Latency : the detection pulse appears one cycle after the last tracked
//           sample is accepted.
// Backpressure: none; every valid sample is consumed. Cycles with tvalid low
//           stall the window, counters and state.
// Ports   : clk_i / reset_ni        clock, async active-low reset
//           s_axis_in_tdata/tvalid  magnitude sample stream
//           peak_detected_o         one-cycle detection pulse
//           peak_value_o/index_o    peak magnitude and sample index, held
//                                   until the next detection
module pss_peak_detector #(
   parameter int IN_DW           = 24,
   parameter int WINDOW_LEN      = 16,
   parameter int DETECTION_SHIFT = 3,
   parameter int MIN_LEVEL       = 256,
   parameter int PEAK_SPAN       = 4,
   parameter int HOLDOFF_LEN     = 64,
   parameter int CNT_DW          = 16
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic [IN_DW-1:0]  s_axis_in_tdata,
   input  logic              s_axis_in_tvalid,
   output logic              peak_detected_o,
   output logic [IN_DW-1:0]  peak_value_o,
   output logic [CNT_DW-1:0] peak_index_o
);

   localparam int LOG2_W = $clog2(WINDOW_LEN);
   localparam int SUM_W  = IN_DW + LOG2_W;
   // Wide enough for both sides of the ratio compare without truncation.
   localparam int CMP_W  = SUM_W + DETECTION_SHIFT + 1;
   localparam int FILL_W = LOG2_W + 1;
   localparam int SPAN_W = $clog2(PEAK_SPAN + 1);
   localparam int HOLD_W = (HOLDOFF_LEN > 0) ? $clog2(HOLDOFF_LEN + 1) : 1;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_TRACK   = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   // Window of preceding samples; index 0 is the most recent.
   logic [IN_DW-1:0]  r_win [WINDOW_LEN];
   logic [SUM_W-1:0]  r_sum;
   logic [FILL_W-1:0] r_fill;
   logic [CNT_DW-1:0] r_cnt;

   state_t            r_state;
   logic [IN_DW-1:0]  r_pk_val;
   logic [CNT_DW-1:0] r_pk_idx;
   logic [SPAN_W-1:0] r_span;
   logic [HOLD_W-1:0] r_hold;

   logic              r_det;
   logic [IN_DW-1:0]  r_val_o;
   logic [CNT_DW-1:0] r_idx_o;

   logic [CMP_W-1:0]  w_lhs;
   logic [CMP_W-1:0]  w_rhs;
   logic              w_full;
   logic              w_trig;

   state_t            w_state_nxt;
   logic [IN_DW-1:0]  w_pk_val_nxt;
   logic [CNT_DW-1:0] w_pk_idx_nxt;
   logic [SPAN_W-1:0] w_span_nxt;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic              w_finish;

   // Ratio test in * W > sum * 2^SHIFT, i.e. in > 2^SHIFT * average.
   assign w_lhs  = {{(CMP_W-IN_DW){1'b0}}, s_axis_in_tdata} << LOG2_W;
   assign w_rhs  = {{(CMP_W-SUM_W){1'b0}}, r_sum} << DETECTION_SHIFT;
   assign w_full = (r_fill == FILL_W'(WINDOW_LEN));
   assign w_trig = w_full
                && (s_axis_in_tdata >= IN_DW'(MIN_LEVEL))
                && (w_lhs > w_rhs);

   // Window, running sum and sample index: updated on every valid sample
   // regardless of the detector state.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < WINDOW_LEN; i++) r_win[i] <= '0;
         r_sum  <= '0;
         r_fill <= '0;
         r_cnt  <= '0;
      end else if (s_axis_in_tvalid) begin
         // Unfilled slots hold zero, so the sum is exact during warm-up too.
         r_sum <= r_sum + SUM_W'(s_axis_in_tdata) - SUM_W'(r_win[WINDOW_LEN-1]);
         r_win[0] <= s_axis_in_tdata;
         for (int i = 1; i < WINDOW_LEN; i++) r_win[i] <= r_win[i-1];
         if (!w_full) r_fill <= r_fill + FILL_W'(1);
         r_cnt <= r_cnt + CNT_DW'(1);
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pk_val_nxt = r_pk_val;
      w_pk_idx_nxt = r_pk_idx;
      w_span_nxt   = r_span;
      w_hold_nxt   = r_hold;
      w_finish     = 1'b0;
      if (s_axis_in_tvalid) begin
         case (r_state)
            ST_SEARCH: begin
               if (w_trig) begin
                  w_pk_val_nxt = s_axis_in_tdata;
                  w_pk_idx_nxt = r_cnt;
                  w_span_nxt   = SPAN_W'(1);
                  if (PEAK_SPAN == 1) w_finish    = 1'b1;
                  else                w_state_nxt = ST_TRACK;
               end
            end
            ST_TRACK: begin
               // Strict compare: on ties the earlier sample wins.
               if (s_axis_in_tdata > r_pk_val) begin
                  w_pk_val_nxt = s_axis_in_tdata;
                  w_pk_idx_nxt = r_cnt;
               end
               w_span_nxt = r_span + SPAN_W'(1);
               if (r_span == SPAN_W'(PEAK_SPAN - 1)) w_finish = 1'b1;
            end
            ST_HOLDOFF: begin
               if (r_hold == HOLD_W'(HOLDOFF_LEN - 1)) begin
                  w_state_nxt = ST_SEARCH;
                  w_hold_nxt  = '0;
               end else begin
                  w_hold_nxt  = r_hold + HOLD_W'(1);
               end
            end
            default: w_state_nxt = ST_SEARCH;
         endcase
      end
      if (w_finish) begin
         w_state_nxt = (HOLDOFF_LEN > 0) ? ST_HOLDOFF : ST_SEARCH;
         w_hold_nxt  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state  <= ST_SEARCH;
         r_pk_val <= '0;
         r_pk_idx <= '0;
         r_span   <= '0;
         r_hold   <= '0;
         r_det    <= 1'b0;
         r_val_o  <= '0;
         r_idx_o  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_pk_val <= w_pk_val_nxt;
         r_pk_idx <= w_pk_idx_nxt;
         r_span   <= w_span_nxt;
         r_hold   <= w_hold_nxt;
         // Pulse is independent of tvalid in the following cycle.
         r_det    <= w_finish;
         if (w_finish) begin
            r_val_o <= w_pk_val_nxt;
            r_idx_o <= w_pk_idx_nxt;
         end
      end
   end

   assign peak_detected_o = r_det;
   assign peak_value_o    = r_val_o;
   assign peak_index_o    = r_idx_o;

endmodule

// File: tb/tb_pss_peak_detector.sv
// Purpose : self-checking bench for pss_peak_detector (default parameters).
// Latency : expects each detection pulse one cycle after the last tracked sample.
// Backpressure: none; stimulus drives samples with optional random idle gaps.
module tb_pss_peak_detector;

   localparam int IN_DW  = 24;
   localparam int CNT_DW = 16;

   logic              clk_i = 1'b0;
   logic              reset_ni;
   logic [IN_DW-1:0]  s_axis_in_tdata;
   logic              s_axis_in_tvalid;
   logic              peak_detected_o;
   logic [IN_DW-1:0]  peak_value_o;
   logic [CNT_DW-1:0] peak_index_o;

   always #5 clk_i = ~clk_i;

   pss_peak_detector dut (
      .clk_i            (clk_i),
      .reset_ni         (reset_ni),
      .s_axis_in_tdata  (s_axis_in_tdata),
      .s_axis_in_tvalid (s_axis_in_tvalid),
      .peak_detected_o  (peak_detected_o),
      .peak_value_o     (peak_value_o),
      .peak_index_o     (peak_index_o)
   );

   // One record = reset (optional) followed by n copies of sample d.
   // If exp is set, a pulse (ev, ei) is due one cycle after the last one.
   typedef struct {
      bit               rst;
      bit               gap;
      int               n;
      logic [IN_DW-1:0] d;
      bit               exp;
      logic [IN_DW-1:0] ev;
      logic [CNT_DW-1:0] ei;
   } vec_t;

   typedef struct {
      logic [IN_DW-1:0]  val;
      logic [CNT_DW-1:0] idx;
      int                due;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   last_cyc = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic void v(bit rst, bit gap, int n, logic [IN_DW-1:0] d,
                             bit e = 1'b0, logic [IN_DW-1:0] ev = '0,
                             logic [CNT_DW-1:0] ei = '0);
      vec_t r;
      r.rst = rst; r.gap = gap; r.n = n; r.d = d;
      r.exp = e;   r.ev = ev;   r.ei = ei;
      vecs.push_back(r);
   endfunction

   // Scoreboard check every cycle, away from the active edge.
   always @(negedge clk_i) begin
      logic exp_det;
      exp_det = (sb.size() > 0) && (sb[0].due == cyc);
      n_vec++;
      if (peak_detected_o !== exp_det) begin
         n_err++;
         $display("FAIL pulse cyc=%0d got=%b want=%b", cyc, peak_detected_o, exp_det);
      end
      if (exp_det) begin
         n_vec += 2;
         if (peak_value_o !== sb[0].val) begin
            n_err++;
            $display("FAIL value cyc=%0d got=%0d want=%0d", cyc, peak_value_o, sb[0].val);
         end
         if (peak_index_o !== sb[0].idx) begin
            n_err++;
            $display("FAIL index cyc=%0d got=%0d want=%0d", cyc, peak_index_o, sb[0].idx);
         end
         void'(sb.pop_front());
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
         void'(sb.pop_front());
      end
   end

   task automatic do_reset();
      @(posedge clk_i); #1;
      reset_ni = 1'b0;
      s_axis_in_tvalid = 1'b0;
      sb.delete();
      #1;
      n_vec += 3;
      if (peak_detected_o !== 1'b0) begin
         n_err++; $display("FAIL rst_det got=%b want=0", peak_detected_o);
      end
      if (peak_value_o !== '0) begin
         n_err++; $display("FAIL rst_val got=%0d want=0", peak_value_o);
      end
      if (peak_index_o !== '0) begin
         n_err++; $display("FAIL rst_idx got=%0d want=0", peak_index_o);
      end
      repeat (2) @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
   endtask

   task automatic send(input logic [IN_DW-1:0] d, input bit gap);
      if (gap) begin
         repeat ($urandom_range(0, 2)) begin
            s_axis_in_tvalid = 1'b0;
            @(posedge clk_i); #1;
         end
      end
      s_axis_in_tdata  = d;
      s_axis_in_tvalid = 1'b1;
      last_cyc = cyc;
      @(posedge clk_i); #1;
      s_axis_in_tvalid = 1'b0;
   endtask

   initial begin
      reset_ni         = 1'b0;
      s_axis_in_tdata  = '0;
      s_axis_in_tvalid = 1'b0;

      // Constant level never exceeds 8x its own average.
      v(1, 0, 200, 1000);
      // Basic detection: max 9000 at idx17 within span 16..19.
      v(1, 0, 16, 1000); v(0, 0, 1, 8001); v(0, 0, 1, 9000);
      v(0, 0, 2, 500, 1, 9000, 17);
      // Same with random tvalid gaps.
      v(1, 1, 16, 1000); v(0, 1, 1, 8001); v(0, 1, 1, 9000);
      v(0, 1, 2, 500, 1, 9000, 17);
      // Exactly 8x average does not trigger.
      v(1, 0, 16, 1000); v(0, 0, 1, 8000); v(0, 0, 3, 1000);
      // Below the floor does not trigger; exactly at the floor does.
      v(1, 0, 16, 10); v(0, 0, 1, 200); v(0, 0, 3, 10);
      v(1, 0, 16, 10); v(0, 0, 1, 256); v(0, 0, 3, 10, 1, 256, 16);
      // Warm-up: large first sample, then 5000 vs sum 100000.
      v(1, 0, 1, 100000); v(0, 0, 15, 0); v(0, 0, 1, 5000); v(0, 0, 3, 0);
      // Warm-up: idx15 would trigger on a zero average if fill were ignored.
      v(1, 0, 15, 0); v(0, 0, 1, 1000); v(0, 0, 20, 0);
      // Tie within the span keeps the earlier sample.
      v(1, 0, 16, 1000); v(0, 0, 2, 9000); v(0, 0, 2, 1000, 1, 9000, 16);
      // Maximum on the last span sample.
      v(1, 0, 16, 1000); v(0, 0, 1, 8001); v(0, 0, 2, 1000);
      v(0, 0, 1, 9000, 1, 9000, 19); v(0, 0, 4, 1000);
      // Hold-off: spike at idx40 ignored, spike at idx84 detected.
      v(1, 0, 16, 1000); v(0, 0, 1, 9000); v(0, 0, 3, 1000, 1, 9000, 16);
      v(0, 0, 20, 1000); v(0, 0, 1, 9000); v(0, 0, 43, 1000);
      v(0, 0, 1, 9000); v(0, 0, 3, 1000, 1, 9000, 84);
      // Hold-off boundary: idx83 is the last ignored sample.
      v(1, 0, 16, 1000); v(0, 0, 1, 9000); v(0, 0, 3, 1000, 1, 9000, 16);
      v(0, 0, 63, 1000); v(0, 0, 1, 9000); v(0, 0, 20, 1000);
      // Reset mid-TRACK aborts; index restarts at 0 afterwards.
      v(1, 0, 16, 1000); v(0, 0, 1, 9000);
      v(1, 0, 16, 1000); v(0, 0, 1, 9000); v(0, 0, 3, 1000, 1, 9000, 16);

      for (int i = 0; i < vecs.size(); i++) begin
         exp_t e;
         if (vecs[i].rst) do_reset();
         for (int k = 0; k < vecs[i].n; k++) send(vecs[i].d, vecs[i].gap);
         if (vecs[i].exp) begin
            e.val = vecs[i].ev;
            e.idx = vecs[i].ei;
            e.due = last_cyc + 1;
            sb.push_back(e);
         end
      end

      repeat (20) @(posedge clk_i);
      #1;
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
